// File: rtl/apb_multi_subordinate.sv
// APB completer that decodes one PSEL into Regions local-bus windows, with wait states,
// a busy timeout and PSLVERR on unmapped accesses. Define APB_SUB_PROT_CHECK_EN to block non-secure access to SecureRegions.
module apb_multi_subordinate #(
  parameter int                           DataWidth     = 32,
  parameter int                           AddrWidth     = 32,
  parameter int                           ProtWidth     = 4,
  parameter int                           Regions       = 2,
  parameter logic [Regions*AddrWidth-1:0] RegionBases   = {32'h200, 32'h100},
  parameter logic [Regions*AddrWidth-1:0] RegionMasks   = {32'hFFFFFF00, 32'hFFFFFF00},
  parameter int                           TimeoutCycles = 16,
  parameter logic [Regions-1:0]           SecureRegions = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           bus_sel,
  input  logic                           bus_enable,
  input  logic                           bus_write,
  input  logic [AddrWidth-1:0]           bus_addr,
  input  logic [DataWidth-1:0]           bus_wData,
  input  logic [DataWidth/8-1:0]         bus_strb,
  input  logic [ProtWidth-1:0]           bus_prot,
  output logic [DataWidth-1:0]           bus_rData,
  output logic                           bus_ready,
  output logic                           bus_subError,
  output logic [Regions-1:0]             sub_wEn,
  output logic [Regions-1:0]             sub_rEn,
  output logic [AddrWidth-1:0]           sub_addr,
  output logic [DataWidth-1:0]           sub_wData,
  output logic [DataWidth/8-1:0]         sub_wStrb,
  output logic [ProtWidth-1:0]           sub_prot,
  input  logic [Regions*DataWidth-1:0]   sub_rData,
  input  logic [Regions-1:0]             sub_error,
  input  logic [Regions-1:0]             sub_busy
);

`ifdef APB_SUB_PROT_CHECK_EN
  localparam bit ProtCheckEn = 1'b1;
`else
  localparam bit ProtCheckEn = 1'b0;
`endif

  localparam bit                TimeoutOn = (TimeoutCycles != 0);
  localparam int                CntW      = TimeoutOn ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0]   CntLast   = CntW'(TimeoutOn ? TimeoutCycles - 1 : 0);
  localparam logic [CntW-1:0]   CntMax    = '1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e                  state_q;
  logic [AddrWidth-1:0]    addr_q;
  logic                    write_q;
  logic [DataWidth-1:0]    wdata_q;
  logic [DataWidth/8-1:0]  strb_q;
  logic [ProtWidth-1:0]    prot_q;
  logic                    mapped_q;
  logic [Regions-1:0]      sel_q;
  logic [CntW-1:0]         cnt_q;
  logic [Regions-1:0]      wen_q;
  logic [Regions-1:0]      ren_q;
  logic                    ready_q;
  logic [DataWidth-1:0]    rdata_q;
  logic                    err_q;

  logic                    hit_d;
  logic                    secure_d;
  logic                    mapped_d;
  logic [Regions-1:0]      sel_d;
  logic [AddrWidth-1:0]    addr_d;

  logic                    busy_sel;
  logic                    err_sel;
  logic [DataWidth-1:0]    rdata_sel;

  // Walk from the top index down so the lowest-numbered overlapping window wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves one unassigned infers a latch.
    hit_d    = 1'b0;
    secure_d = 1'b0;
    sel_d    = '0;
    addr_d   = '0;
    for (int i = Regions - 1; i >= 0; i--) begin
      if ((bus_addr & RegionMasks[i*AddrWidth +: AddrWidth]) ==
          (RegionBases[i*AddrWidth +: AddrWidth] & RegionMasks[i*AddrWidth +: AddrWidth])) begin
        hit_d    = 1'b1;
        secure_d = SecureRegions[i];
        sel_d    = '0;
        sel_d[i] = 1'b1;
        addr_d   = bus_addr & ~RegionMasks[i*AddrWidth +: AddrWidth];
      end
    end
    mapped_d = hit_d && !(ProtCheckEn && secure_d && bus_prot[1]);
  end

  // Pick the selected region's status lines using the latched one-hot window select.
  always_comb begin
    busy_sel  = 1'b0;
    err_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < Regions; i++) begin
      if (sel_q[i]) begin
        busy_sel  = sub_busy[i];
        err_sel   = sub_error[i];
        rdata_sel = sub_rData[i*DataWidth +: DataWidth];
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prot_q   <= '0;
      mapped_q <= 1'b0;
      sel_q    <= '0;
      cnt_q    <= '0;
      wen_q    <= '0;
      ren_q    <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_sel && !bus_enable) begin
            state_q  <= ACCESS;
            addr_q   <= addr_d;
            write_q  <= bus_write;
            wdata_q  <= bus_wData;
            strb_q   <= bus_strb;
            prot_q   <= bus_prot;
            mapped_q <= mapped_d;
            sel_q    <= mapped_d ? sel_d : '0;
            cnt_q    <= '0;
            wen_q    <= (mapped_d && bus_write)  ? sel_d : '0;
            ren_q    <= (mapped_d && !bus_write) ? sel_d : '0;
          end
        end

        ACCESS: begin
          if (!bus_sel) begin
            state_q <= IDLE;
            wen_q   <= '0;
            ren_q   <= '0;
          end else if (!mapped_q) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
          end else if (!busy_sel) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            rdata_q <= write_q ? '0 : rdata_sel;
            err_q   <= err_sel;
            wen_q   <= '0;
            ren_q   <= '0;
          end else if (TimeoutOn && (cnt_q == CntLast)) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            wen_q   <= '0;
            ren_q   <= '0;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Enables are gated by PSEL so an aborted transfer never shows a local strobe.
  assign sub_wEn      = wen_q & {Regions{bus_sel}};
  assign sub_rEn      = ren_q & {Regions{bus_sel}};
  assign sub_addr     = addr_q;
  assign sub_wData    = wdata_q;
  assign sub_wStrb    = strb_q;
  assign sub_prot     = prot_q;
  assign bus_ready    = ready_q;
  assign bus_rData    = rdata_q;
  assign bus_subError = err_q;

endmodule

// File: tb/tb_apb_multi_subordinate.sv
// Directed self-checking bench for apb_multi_subordinate with the default two-window map
// (0x100 region 0, 0x200 region 1) and a 16-cycle busy timeout.
module tb_apb_multi_subordinate;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_sel;
  logic        bus_enable;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wData;
  logic [3:0]  bus_strb;
  logic [3:0]  bus_prot;
  logic [31:0] bus_rData;
  logic        bus_ready;
  logic        bus_subError;
  logic [1:0]  sub_wEn;
  logic [1:0]  sub_rEn;
  logic [31:0] sub_addr;
  logic [31:0] sub_wData;
  logic [3:0]  sub_wStrb;
  logic [3:0]  sub_prot;
  logic [63:0] sub_rData;
  logic [1:0]  sub_error;
  logic [1:0]  sub_busy;

  int tests_run = 0;
  int failed    = 0;

  apb_multi_subordinate #(
    .DataWidth    (32),
    .AddrWidth    (32),
    .ProtWidth    (4),
    .Regions      (2),
    .RegionBases  ({32'h200, 32'h100}),
    .RegionMasks  ({32'hFFFFFF00, 32'hFFFFFF00}),
    .TimeoutCycles(16),
    .SecureRegions(2'b01)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_sel     (bus_sel),
    .bus_enable  (bus_enable),
    .bus_write   (bus_write),
    .bus_addr    (bus_addr),
    .bus_wData   (bus_wData),
    .bus_strb    (bus_strb),
    .bus_prot    (bus_prot),
    .bus_rData   (bus_rData),
    .bus_ready   (bus_ready),
    .bus_subError(bus_subError),
    .sub_wEn     (sub_wEn),
    .sub_rEn     (sub_rEn),
    .sub_addr    (sub_addr),
    .sub_wData   (sub_wData),
    .sub_wStrb   (sub_wStrb),
    .sub_prot    (sub_prot),
    .sub_rData   (sub_rData),
    .sub_error   (sub_error),
    .sub_busy    (sub_busy)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 ns after the rising edge, inputs are changed at the same point.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    bus_sel    = 1'b0;
    bus_enable = 1'b0;
  endtask

  // Drives one setup cycle, then raises PENABLE; returns in the first ACCESS cycle.
  task automatic setup_phase(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic [3:0] prot);
    bus_sel    = 1'b1;
    bus_enable = 1'b0;
    bus_write  = wr;
    bus_addr   = addr;
    bus_wData  = wdata;
    bus_strb   = strb;
    bus_prot   = prot;
    tick;
    bus_enable = 1'b1;
  endtask

  task automatic test_reset;
    logic [112:0] all_out;
    reset = 1'b1;
    tick;
    tick;
    all_out = {bus_ready, bus_subError, bus_rData, sub_wEn, sub_rEn, sub_addr, sub_wData, sub_wStrb, sub_prot};
    tests_run++;
    if (all_out !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    reset = 1'b0;
    tick;
    tests_run++;
    if (bus_ready !== 1'b0) begin
      failed++;
      $display("FAIL reset_idle_ready: got %b expected 0", bus_ready);
    end
  endtask

  task automatic test_write_single;
    sub_busy  = 2'b00;
    sub_error = 2'b00;
    setup_phase(1'b1, 32'h104, 32'hDEADBEEF, 4'hF, 4'h0);
    tests_run++;
    if ({sub_wEn, sub_rEn} !== 4'b0100) begin
      failed++;
      $display("FAIL wr_enables: got wEn=%b rEn=%b expected wEn=01 rEn=00", sub_wEn, sub_rEn);
    end
    tests_run++;
    if (sub_addr !== 32'h4) begin
      failed++;
      $display("FAIL wr_offset: got %h expected 00000004", sub_addr);
    end
    tests_run++;
    if ({sub_wData, sub_wStrb} !== {32'hDEADBEEF, 4'hF}) begin
      failed++;
      $display("FAIL wr_data_strb: got %h/%h expected deadbeef/f", sub_wData, sub_wStrb);
    end
    tests_run++;
    if (bus_ready !== 1'b0) begin
      failed++;
      $display("FAIL wr_ready_early: got %b expected 0", bus_ready);
    end
    tick;
    tests_run++;
    if ({bus_ready, bus_subError, bus_rData, sub_wEn} !== {1'b1, 1'b0, 32'h0, 2'b00}) begin
      failed++;
      $display("FAIL wr_resp: got ready=%b err=%b rdata=%h wEn=%b expected 1/0/0/00",
               bus_ready, bus_subError, bus_rData, sub_wEn);
    end
    bus_idle;
    tick;
    tests_run++;
    if (bus_ready !== 1'b0) begin
      failed++;
      $display("FAIL wr_single_cycle_ready: got %b expected 0", bus_ready);
    end
  endtask

  task automatic test_read_wait;
    int ren_cycles = 0;
    int ready_at   = 0;
    sub_rData = {32'h12345678, 32'h0BAD0BAD};
    sub_busy  = 2'b10;
    setup_phase(1'b0, 32'h2A0, 32'h0, 4'h0, 4'h0);
    tests_run++;
    if (sub_addr !== 32'hA0) begin
      failed++;
      $display("FAIL rd_offset: got %h expected 000000a0", sub_addr);
    end
    for (int c = 1; c <= 10 && ready_at == 0; c++) begin
      if (c == 4) sub_busy = 2'b00;
      if (bus_ready === 1'b1) begin
        ready_at = c;
      end else begin
        if (sub_rEn === 2'b10 && sub_wEn === 2'b00) ren_cycles++;
        tick;
      end
    end
    tests_run++;
    if (ready_at != 5) begin
      failed++;
      $display("FAIL rd_wait_latency: got access cycle %0d expected 5", ready_at);
    end
    tests_run++;
    if (ren_cycles != 4) begin
      failed++;
      $display("FAIL rd_wait_ren_cycles: got %0d expected 4", ren_cycles);
    end
    tests_run++;
    if ({bus_rData, bus_subError, sub_rEn} !== {32'h12345678, 1'b0, 2'b00}) begin
      failed++;
      $display("FAIL rd_wait_resp: got rdata=%h err=%b rEn=%b expected 12345678/0/00",
               bus_rData, bus_subError, sub_rEn);
    end
    bus_idle;
    tick;
  endtask

  task automatic test_unmapped;
    sub_rData = {32'hFFFFFFFF, 32'hFFFFFFFF};
    sub_busy  = 2'b00;
    setup_phase(1'b0, 32'h300, 32'h0, 4'h0, 4'h0);
    tests_run++;
    if ({sub_wEn, sub_rEn, bus_ready} !== 5'b00000) begin
      failed++;
      $display("FAIL unmapped_access: got wEn=%b rEn=%b ready=%b expected 00/00/0", sub_wEn, sub_rEn, bus_ready);
    end
    tick;
    tests_run++;
    if ({bus_ready, bus_subError, bus_rData} !== {1'b1, 1'b1, 32'h0}) begin
      failed++;
      $display("FAIL unmapped_resp: got ready=%b err=%b rdata=%h expected 1/1/0", bus_ready, bus_subError, bus_rData);
    end
    bus_idle;
    tick;
  endtask

  task automatic test_local_error;
    sub_busy  = 2'b00;
    sub_error = 2'b10;
    setup_phase(1'b1, 32'h2FC, 32'h55AA33CC, 4'b0101, 4'h5);
    tests_run++;
    if ({sub_wEn, sub_addr, sub_wStrb, sub_prot} !== {2'b10, 32'hFC, 4'b0101, 4'h5}) begin
      failed++;
      $display("FAIL err_access: got wEn=%b addr=%h strb=%b prot=%h expected 10/fc/0101/5",
               sub_wEn, sub_addr, sub_wStrb, sub_prot);
    end
    tick;
    tests_run++;
    if ({bus_ready, bus_subError} !== 2'b11) begin
      failed++;
      $display("FAIL err_resp: got ready=%b err=%b expected 1/1", bus_ready, bus_subError);
    end
    sub_error = 2'b00;
    bus_idle;
    tick;
  endtask

  task automatic test_timeout;
    int wen_cycles = 0;
    int ready_at   = 0;
    sub_busy = 2'b01;
    setup_phase(1'b1, 32'h108, 32'hCAFEBABE, 4'hF, 4'h0);
    for (int c = 1; c <= 30 && ready_at == 0; c++) begin
      if (bus_ready === 1'b1) begin
        ready_at = c;
      end else begin
        if (sub_wEn === 2'b01) wen_cycles++;
        tick;
      end
    end
    tests_run++;
    if (ready_at != 17) begin
      failed++;
      $display("FAIL timeout_latency: got access cycle %0d expected 17", ready_at);
    end
    tests_run++;
    if (wen_cycles != 16) begin
      failed++;
      $display("FAIL timeout_wen_cycles: got %0d expected 16", wen_cycles);
    end
    tests_run++;
    if ({bus_subError, bus_rData, sub_wEn, sub_rEn} !== {1'b1, 32'h0, 2'b00, 2'b00}) begin
      failed++;
      $display("FAIL timeout_resp: got err=%b rdata=%h wEn=%b rEn=%b expected 1/0/00/00",
               bus_subError, bus_rData, sub_wEn, sub_rEn);
    end
    sub_busy = 2'b00;
    bus_idle;
    tick;
  endtask

  task automatic test_abort;
    int ready_seen = 0;
    sub_busy = 2'b01;
    setup_phase(1'b0, 32'h100, 32'h0, 4'h0, 4'h0);
    tests_run++;
    if (sub_rEn !== 2'b01) begin
      failed++;
      $display("FAIL abort_before: got rEn=%b expected 01", sub_rEn);
    end
    bus_idle;
    sub_busy = 2'b00;
    for (int c = 0; c < 3; c++) begin
      tick;
      if (bus_ready !== 1'b0 || sub_rEn !== 2'b00) ready_seen++;
    end
    tests_run++;
    if (ready_seen != 0) begin
      failed++;
      $display("FAIL abort_no_resp: got %0d active cycles expected 0", ready_seen);
    end
  endtask

  task automatic test_reset_mid;
    logic [112:0] all_out;
    sub_busy = 2'b01;
    setup_phase(1'b0, 32'h100, 32'h0, 4'h0, 4'h3);
    tick;
    tick;
    reset = 1'b1;
    bus_idle;
    tick;
    all_out = {bus_ready, bus_subError, bus_rData, sub_wEn, sub_rEn, sub_addr, sub_wData, sub_wStrb, sub_prot};
    tests_run++;
    if (all_out !== '0) begin
      failed++;
      $display("FAIL reset_mid_outputs: got %h expected 0", all_out);
    end
    reset     = 1'b0;
    sub_busy  = 2'b00;
    sub_rData = {32'h0, 32'hA5A50001};
    tick;
    setup_phase(1'b0, 32'h100, 32'h0, 4'h0, 4'h0);
    tests_run++;
    if (sub_rEn !== 2'b01) begin
      failed++;
      $display("FAIL reset_mid_next_ren: got %b expected 01", sub_rEn);
    end
    tick;
    tests_run++;
    if ({bus_ready, bus_subError, bus_rData} !== {1'b1, 1'b0, 32'hA5A50001}) begin
      failed++;
      $display("FAIL reset_mid_next_resp: got ready=%b err=%b rdata=%h expected 1/0/a5a50001",
               bus_ready, bus_subError, bus_rData);
    end
    bus_idle;
    tick;
  endtask

  task automatic test_back_to_back;
    sub_busy  = 2'b00;
    sub_rData = {32'h77778888, 32'h0};
    setup_phase(1'b1, 32'h1F0, 32'h11112222, 4'hF, 4'h0);
    tick;
    tests_run++;
    if (bus_ready !== 1'b1) begin
      failed++;
      $display("FAIL b2b_first_ready: got %b expected 1", bus_ready);
    end
    tick;
    tests_run++;
    if (bus_ready !== 1'b0) begin
      failed++;
      $display("FAIL b2b_gap_ready: got %b expected 0", bus_ready);
    end
    setup_phase(1'b0, 32'h2A4, 32'h0, 4'h0, 4'h0);
    tests_run++;
    if ({sub_rEn, sub_addr} !== {2'b10, 32'hA4}) begin
      failed++;
      $display("FAIL b2b_second_access: got rEn=%b addr=%h expected 10/a4", sub_rEn, sub_addr);
    end
    tick;
    tests_run++;
    if ({bus_ready, bus_rData} !== {1'b1, 32'h77778888}) begin
      failed++;
      $display("FAIL b2b_second_resp: got ready=%b rdata=%h expected 1/77778888", bus_ready, bus_rData);
    end
    bus_idle;
    tick;
  endtask

  task automatic test_prot;
    sub_busy  = 2'b00;
    sub_rData = {32'h0, 32'h0F0F0F0F};
    setup_phase(1'b0, 32'h100, 32'h0, 4'h0, 4'b0010);
`ifdef APB_SUB_PROT_CHECK_EN
    tests_run++;
    if (sub_rEn !== 2'b00) begin
      failed++;
      $display("FAIL prot_blocked_ren: got %b expected 00", sub_rEn);
    end
    tick;
    tests_run++;
    if ({bus_ready, bus_subError, bus_rData} !== {1'b1, 1'b1, 32'h0}) begin
      failed++;
      $display("FAIL prot_blocked_resp: got ready=%b err=%b rdata=%h expected 1/1/0",
               bus_ready, bus_subError, bus_rData);
    end
`else
    tests_run++;
    if ({sub_rEn, sub_prot} !== {2'b01, 4'b0010}) begin
      failed++;
      $display("FAIL prot_forward: got rEn=%b prot=%b expected 01/0010", sub_rEn, sub_prot);
    end
    tick;
    tests_run++;
    if ({bus_ready, bus_subError, bus_rData} !== {1'b1, 1'b0, 32'h0F0F0F0F}) begin
      failed++;
      $display("FAIL prot_ignored_resp: got ready=%b err=%b rdata=%h expected 1/0/0f0f0f0f",
               bus_ready, bus_subError, bus_rData);
    end
`endif
    bus_idle;
    tick;
    setup_phase(1'b0, 32'h100, 32'h0, 4'h0, 4'h0);
    tick;
    tests_run++;
    if ({bus_ready, bus_subError, bus_rData} !== {1'b1, 1'b0, 32'h0F0F0F0F}) begin
      failed++;
      $display("FAIL prot_secure_resp: got ready=%b err=%b rdata=%h expected 1/0/0f0f0f0f",
               bus_ready, bus_subError, bus_rData);
    end
    bus_idle;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    bus_sel    = 1'b0;
    bus_enable = 1'b0;
    bus_write  = 1'b0;
    bus_addr   = '0;
    bus_wData  = '0;
    bus_strb   = '0;
    bus_prot   = '0;
    sub_rData  = '0;
    sub_error  = '0;
    sub_busy   = '0;

    test_reset;
    test_write_single;
    test_read_wait;
    test_unmapped;
    test_local_error;
    test_timeout;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    test_prot;

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/apb_multi_subordinate.md
Name: apb_multi_subordinate

Overview:
- Parametrised APB completer that decodes one PSEL into `Regions` address windows, each driving its own generic local-bus channel.
- Adds wait states driven by local `busy`, a wait-state timeout, error response on unmapped addresses, and region-relative address offsets.
- Sits between the APB requester/decoder and up to `Regions` generic-bus peripherals; replaces a single-window, zero-wait subordinate.

Parameters:
- DataWidth, 32, data bus width; multiple of 8.
- AddrWidth, 32, address width.
- ProtWidth, 4, protection field width.
- Regions, 2, number of address windows / local channels (1..16).
- RegionBases, {32'h200, 32'h100}, packed Regions*AddrWidth; region i base at slice i.
- RegionMasks, {32'hFFFFFF00, 32'hFFFFFF00}, packed Regions*AddrWidth; 1 bits compared.
- TimeoutCycles, 16, max busy cycles in ACCESS before forced error; 0 disables timeout.
- SecureRegions, 0, Regions-bit mask; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- bus_sel  in  1  PSEL for this completer.
- bus_enable  in  1  PENABLE.
- bus_write  in  1  PWRITE.
- bus_addr  in  AddrWidth  PADDR.
- bus_wData  in  DataWidth  PWDATA.
- bus_strb  in  DataWidth/8  PSTRB.
- bus_prot  in  ProtWidth  PPROT.
- bus_rData  out  DataWidth  PRDATA.
- bus_ready  out  1  PREADY.
- bus_subError  out  1  PSLVERR.
- sub_wEn  out  Regions  per-region write enable.
- sub_rEn  out  Regions  per-region read enable.
- sub_addr  out  AddrWidth  offset = latched addr & ~RegionMasks[idx].
- sub_wData  out  DataWidth  latched write data.
- sub_wStrb  out  DataWidth/8  latched strobes.
- sub_prot  out  ProtWidth  latched prot.
- sub_rData  in  Regions*DataWidth  per-region read data, slice i.
- sub_error  in  Regions  per-region error.
- sub_busy  in  Regions  per-region busy (wait request).

Behaviour:
- Reset: state IDLE; all outputs 0; wait counter 0; latches 0.
- Hit i: (bus_addr & Mask[i]) == (Base[i] & Mask[i]). Overlaps resolve to the lowest index. No hit makes the access unmapped.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On bus_sel & !bus_enable (setup phase): latch addr, write, wData, strb, prot, hit flag and region idx; clear the counter; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (every cycle):
  - If bus_sel=0, abort: go to IDLE with no response.
  - If unmapped: set err=1, rdata=0; go to RESP. No local enable asserts.
  - Otherwise drive sub_wEn[idx]=write or sub_rEn[idx]=!write. All other enable bits are 0.
  - If sub_busy[idx]=0: capture rdata (sub_rData slice on reads, 0 on writes) and err=sub_error[idx]; go to RESP.
  - Else if TimeoutCycles!=0 and counter==TimeoutCycles-1: set err=1, rdata=0; go to RESP.
  - Else increment the counter.
- RESP:
  - bus_ready=1, bus_rData=captured rdata, bus_subError=captured err, for exactly one cycle. Then go to IDLE.
  - Local enables are 0.
- Outside RESP: bus_ready=0, bus_rData=0, bus_subError=0.
- Latency: the zero-busy access completes with PREADY in the 2nd ACCESS-phase cycle (1 wait state). Each busy cycle adds 1.
- Timeout: with busy stuck high, PREADY comes TimeoutCycles cycles after entering ACCESS plus 1, with PSLVERR=1. Local enables drop in RESP.
- Back-to-back: a setup phase seen in the cycle after RESP is accepted normally.
- Reset mid-transfer: returns to IDLE next edge and drops all outputs; no response is issued.
- The counter width is $clog2(TimeoutCycles+1) and never wraps.

Optional Feature:
- APB_SUB_PROT_CHECK_EN defined:
  - An access hitting region i where SecureRegions[i]=1 and bus_prot[1]=1 (non-secure) is treated like unmapped.
  - Result: err=1, rdata=0, no local enable, response in the 1st ACCESS cycle + 1.
- Undefined: prot does not affect decode; it is only forwarded on sub_prot; SecureRegions is ignored.

Test Plan:
- Write 0xDEADBEEF, strb 0xF, to 0x104, busy=0 -> sub_wEn=2'b01 for 1 cycle, sub_addr=0x04, sub_wData=0xDEADBEEF; PREADY=1, PSLVERR=0 in 2nd access cycle.
- Read 0x2A0, region 1 busy for 3 cycles, sub_rData[1]=0x12345678 -> sub_rEn=2'b10 for 4 cycles; PREADY in access cycle 5 with PRDATA=0x12345678.
- Read 0x300 (unmapped) -> no sub_rEn; PREADY=1, PSLVERR=1, PRDATA=0 in 2nd access cycle.
- Write 0x108 with busy stuck high, TimeoutCycles=16 -> sub_wEn high 16 cycles; PREADY=1, PSLVERR=1 on the 17th; enables 0.
- Assert reset during busy ACCESS -> next cycle all outputs 0 and state IDLE; a following read to 0x100 completes normally.
- APB_SUB_PROT_CHECK_EN, SecureRegions=2'b01, read 0x100 with prot=3'b010 -> PSLVERR=1, no sub_rEn; the same read with prot=0 succeeds.
